// File: rtl/game_pkg.sv
// game_pkg: FSM state encoding and accelerometer sample width shared by the
// physics scheduler and its filter.
package game_pkg;
    localparam int ACCEL_W = 8;
    typedef enum logic [2:0] {IDLE, REQ, FILTER, STEP, RESTART} state_t;
endpackage

// File: rtl/accel_filter.sv
// accel_filter: combinational dead-zone and arithmetic shift for one axis.
// The value is widened to 9 bits so that |-128| fits.
module accel_filter
    import game_pkg::*;
#(
    parameter int DEAD_ZONE   = 2,
    parameter int ACCEL_SHIFT = 2
) (
    input  logic [ACCEL_W-1:0] i_a,
    output logic [ACCEL_W-1:0] o_a
);
    logic signed [ACCEL_W:0] w_wide;
    logic        [ACCEL_W:0] w_mag;

    assign w_wide = $signed({i_a[ACCEL_W-1], i_a});
    assign w_mag  = w_wide[ACCEL_W] ? $unsigned(-w_wide) : $unsigned(w_wide);
    assign o_a    = (int'(w_mag) <= DEAD_ZONE) ? '0 : ACCEL_W'(w_wide >>> ACCEL_SHIFT);
endmodule

// File: rtl/physics_scheduler.sv
// physics_scheduler: turns vsync pulses into accelerometer sampling and a
// one-cycle physics step; handles pause, restart, overrun and ack timeouts.
module physics_scheduler
    import game_pkg::*;
#(
    parameter int STEP_DIV       = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DEAD_ZONE      = 2,
    parameter int ACCEL_SHIFT    = 2
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               i_vsync,
    input  logic               i_pause,
    input  logic               i_restart,
    output logic               o_accel_req,
    input  logic               i_accel_ack,
    input  logic [ACCEL_W-1:0] i_accel_x,
    input  logic [ACCEL_W-1:0] i_accel_y,
    output logic [ACCEL_W-1:0] o_accel_x,
    output logic [ACCEL_W-1:0] o_accel_y,
    output logic               o_step,
    output logic               o_ball_rst_n,
    output logic               o_busy,
    output logic               o_overrun,
    output logic [7:0]         o_timeout_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    logic [7:0]         r_div;
    logic [TW-1:0]      r_wait;
    logic               r_rcnt;
    logic               r_req;
    logic               r_step;
    logic               r_ball_rst_n;
    logic               r_overrun;
    logic [7:0]         r_tcnt;
    logic [ACCEL_W-1:0] r_raw_x, r_raw_y, r_out_x, r_out_y;
    logic [ACCEL_W-1:0] w_filt_x, w_filt_y;

    accel_filter #(.DEAD_ZONE(DEAD_ZONE), .ACCEL_SHIFT(ACCEL_SHIFT)) u_filt_x (
        .i_a(r_raw_x),
        .o_a(w_filt_x)
    );

    accel_filter #(.DEAD_ZONE(DEAD_ZONE), .ACCEL_SHIFT(ACCEL_SHIFT)) u_filt_y (
        .i_a(r_raw_y),
        .o_a(w_filt_y)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= IDLE;
            r_div        <= '0;
            r_wait       <= '0;
            r_rcnt       <= 1'b0;
            r_req        <= 1'b0;
            r_step       <= 1'b0;
            r_ball_rst_n <= 1'b0;
            r_overrun    <= 1'b0;
            r_tcnt       <= '0;
            r_raw_x      <= '0;
            r_raw_y      <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
        end else if (i_restart) begin
            r_state      <= RESTART;
            r_rcnt       <= 1'b0;
            r_req        <= 1'b0;
            r_step       <= 1'b0;
            r_ball_rst_n <= 1'b0;
            r_overrun    <= 1'b0;
            r_div        <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
        end else begin
            r_step <= 1'b0;
            if (i_vsync && r_state != IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    r_ball_rst_n <= 1'b1;
                    if (i_vsync && !i_pause) begin
                        if (r_div == 8'(STEP_DIV - 1)) begin
                            r_div   <= '0;
                            r_wait  <= '0;
                            r_req   <= 1'b1;
                            r_state <= REQ;
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                end
                REQ: begin
                    if (i_accel_ack) begin
                        r_raw_x <= i_accel_x;
                        r_raw_y <= i_accel_y;
                        r_req   <= 1'b0;
                        r_state <= FILTER;
                    end else if (r_wait == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_raw_x <= '0;
                        r_raw_y <= '0;
                        r_req   <= 1'b0;
                        if (r_tcnt != 8'hFF)
                            r_tcnt <= r_tcnt + 8'd1;
                        r_state <= FILTER;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                FILTER: begin
                    r_out_x <= w_filt_x;
                    r_out_y <= w_filt_y;
                    r_step  <= 1'b1;
                    r_state <= STEP;
                end
                STEP: r_state <= IDLE;
                RESTART: begin
                    if (r_rcnt) begin
                        r_ball_rst_n <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_rcnt <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_accel_req   = r_req;
    assign o_accel_x     = r_out_x;
    assign o_accel_y     = r_out_y;
    assign o_step        = r_step;
    assign o_ball_rst_n  = r_ball_rst_n;
    assign o_busy        = (r_state != IDLE);
    assign o_overrun     = r_overrun;
    assign o_timeout_cnt = r_tcnt;
endmodule

// File: tb/tb_physics_scheduler.sv
// tb_physics_scheduler: directed and randomized checks of two scheduler
// instances (STEP_DIV=1 and STEP_DIV=3) against a behavioural model.
module tb_physics_scheduler;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic arst_n, pause, restart;
    logic a_vsync, a_ack, b_vsync, b_ack;
    logic [7:0] a_x, a_y;
    logic [7:0] b_x = 8'd7;
    logic [7:0] b_y = 8'hF8;
    logic a_req, a_step, a_brst, a_busy, a_ovr;
    logic b_req, b_step, b_brst, b_busy, b_ovr;
    logic [7:0] a_ox, a_oy, a_tcnt, b_ox, b_oy, b_tcnt;

    int total = 0;
    int bad = 0;
    int exp_x = 0;
    int exp_y = 0;
    int tcnt_m = 0;
    int b_steps = 0;

    always #5 clk = ~clk;

    physics_scheduler #(.STEP_DIV(1), .TIMEOUT_CYCLES(TO), .DEAD_ZONE(2), .ACCEL_SHIFT(2)) u_a (
        .clk(clk), .arst_n(arst_n), .i_vsync(a_vsync), .i_pause(pause), .i_restart(restart),
        .o_accel_req(a_req), .i_accel_ack(a_ack), .i_accel_x(a_x), .i_accel_y(a_y),
        .o_accel_x(a_ox), .o_accel_y(a_oy), .o_step(a_step), .o_ball_rst_n(a_brst),
        .o_busy(a_busy), .o_overrun(a_ovr), .o_timeout_cnt(a_tcnt)
    );

    physics_scheduler #(.STEP_DIV(3), .TIMEOUT_CYCLES(TO), .DEAD_ZONE(2), .ACCEL_SHIFT(2)) u_b (
        .clk(clk), .arst_n(arst_n), .i_vsync(b_vsync), .i_pause(pause), .i_restart(restart),
        .o_accel_req(b_req), .i_accel_ack(b_ack), .i_accel_x(b_x), .i_accel_y(b_y),
        .o_accel_x(b_ox), .o_accel_y(b_oy), .o_step(b_step), .o_ball_rst_n(b_brst),
        .o_busy(b_busy), .o_overrun(b_ovr), .o_timeout_cnt(b_tcnt)
    );

    function automatic int filt(input int a);
        int m;
        m = (a < 0) ? -a : a;
        if (m <= 2) return 0;
        return (a >= 0) ? a / 4 : -((-a + 3) / 4);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_tick();
        b_ack = b_req;
        tick();
        b_ack = 1'b0;
        if (b_step === 1'b1) b_steps++;
    endtask

    task automatic b_run(input int nv, input int gap);
        for (int v = 0; v < nv; v++) begin
            b_vsync = 1'b1;
            b_tick();
            b_vsync = 1'b0;
            repeat (gap - 1) b_tick();
        end
    endtask

    task automatic run_a(input int dly, input int x, input int y, input bit pz);
        int cnt;
        int hi;
        a_vsync = 1'b1;
        tick();
        a_vsync = 1'b0;
        pause = pz;
        cnt = 0;
        while (a_req === 1'b1 && cnt < 40) begin
            if (cnt == dly) begin
                a_ack = 1'b1;
                a_x = 8'(x);
                a_y = 8'(y);
            end
            tick();
            a_ack = 1'b0;
            cnt++;
        end
        hi = (dly < TO) ? dly + 1 : TO;
        chk("req_len", cnt, hi);
        if (dly < TO) begin
            exp_x = filt(x);
            exp_y = filt(y);
        end else begin
            exp_x = 0;
            exp_y = 0;
            tcnt_m = (tcnt_m < 255) ? tcnt_m + 1 : 255;
        end
        chk("step_early", a_step, 0);
        a_ack = 1'b1;
        a_x = 8'($urandom);
        a_y = 8'($urandom);
        tick();
        a_ack = 1'b0;
        chk("step_pulse", a_step, 1);
        chk("accel_x", $signed(a_ox), exp_x);
        chk("accel_y", $signed(a_oy), exp_y);
        chk("timeout_cnt", a_tcnt, tcnt_m);
        tick();
        chk("step_off", a_step, 0);
        chk("idle_busy", a_busy, 0);
        chk("accel_x_hold", $signed(a_ox), exp_x);
        pause = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        arst_n = 1'b0; pause = 1'b0; restart = 1'b0;
        a_vsync = 1'b0; a_ack = 1'b0; a_x = '0; a_y = '0;
        b_vsync = 1'b0; b_ack = 1'b0;
        #23;
        chk("rst_req", a_req, 0);
        chk("rst_step", a_step, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ovr", a_ovr, 0);
        chk("rst_ox", a_ox, 0);
        chk("rst_tcnt", a_tcnt, 0);
        chk("rst_brst", a_brst, 0);
        arst_n = 1'b1;
        tick();
        chk("brst_release", a_brst, 1);

        run_a(2, 40, -40, 1'b0);
        run_a(1, 2, -3, 1'b0);
        run_a(0, -128, 127, 1'b0);
        run_a(20, 55, 66, 1'b0);

        b_steps = 0;
        b_run(6, 8);
        chk("div3_steps", b_steps, 2);
        chk("div3_ox", $signed(b_ox), filt(7));
        chk("div3_oy", $signed(b_oy), filt(-8));
        chk("div3_ovr_clear", b_ovr, 0);
        b_steps = 0;
        b_run(2, 8);
        b_vsync = 1'b1;
        b_tick();
        chk("b_req_up", b_req, 1);
        b_tick();
        b_vsync = 1'b0;
        repeat (8) b_tick();
        chk("ovr_steps", b_steps, 1);
        chk("ovr_flag", b_ovr, 1);
        b_steps = 0;
        b_run(2, 8);
        chk("ovr_div_kept", b_steps, 0);

        pause = 1'b1;
        n = 0;
        repeat (4) begin
            a_vsync = 1'b1; b_vsync = 1'b1;
            tick();
            a_vsync = 1'b0; b_vsync = 1'b0;
            if (a_req === 1'b1 || b_req === 1'b1) n++;
            tick();
        end
        pause = 1'b0;
        chk("pause_noreq", n, 0);
        b_steps = 0;
        b_run(1, 8);
        chk("pause_div_kept", b_steps, 1);
        chk("b_tcnt", b_tcnt, 0);
        chk("b_brst", b_brst, 1);
        chk("b_busy", b_busy, 0);

        run_a(0, 100, -100, 1'b0);
        a_vsync = 1'b1;
        tick();
        a_vsync = 1'b0;
        chk("rs_req_up", a_req, 1);
        a_ack = 1'b1; a_x = 8'd40; a_y = 8'd40; restart = 1'b1;
        tick();
        a_ack = 1'b0; restart = 1'b0;
        exp_x = 0; exp_y = 0;
        chk("rs_req_drop", a_req, 0);
        chk("rs_brst1", a_brst, 0);
        chk("rs_ox", a_ox, 0);
        chk("rs_oy", a_oy, 0);
        chk("rs_step1", a_step, 0);
        chk("rs_b_ovr_clr", b_ovr, 0);
        tick();
        chk("rs_brst2", a_brst, 0);
        chk("rs_step2", a_step, 0);
        a_vsync = 1'b1;
        tick();
        a_vsync = 1'b0;
        chk("rs_brst_up", a_brst, 1);
        chk("rs_idle", a_busy, 0);
        tick();
        chk("rs_vsync_ignored", a_req, 0);
        chk("rs_tcnt_kept", a_tcnt, tcnt_m);

        restart = 1'b1;
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n = 0;
        while (a_brst === 1'b0 && n < 10) begin
            n++;
            tick();
        end
        chk("retrig_len", n, 2);

        for (int i = 0; i < 30; i++)
            run_a(int'($urandom_range(0, 18)), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));

        a_vsync = 1'b1;
        tick();
        tick();
        a_vsync = 1'b0;
        chk("ar_req_up", a_req, 1);
        chk("ar_ovr_set", a_ovr, 1);
        #1 arst_n = 1'b0;
        #1;
        chk("ar_req", a_req, 0);
        chk("ar_busy", a_busy, 0);
        chk("ar_step", a_step, 0);
        chk("ar_ovr", a_ovr, 0);
        chk("ar_ox", a_ox, 0);
        chk("ar_oy", a_oy, 0);
        chk("ar_tcnt", a_tcnt, 0);
        chk("ar_brst", a_brst, 0);
        #2 arst_n = 1'b1;
        tick();
        chk("ar_brst_up", a_brst, 1);
        chk("ar_idle", a_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
